// File: rtl/ble_crc_pkg.sv
// Shared BLE CRC24 definitions: polynomial, lengths, checker states and the
// single LFSR step used by both the TX generator and the RX checker.
package ble_crc_pkg;

  localparam int          CRC_LEN       = 24;
  localparam logic [23:0] CRC_POLY_TAPS = 24'h00065B;
  localparam logic [23:0] BLE_ADV_INIT  = 24'h555555;
  localparam int          MAX_PDU_BYTES = 257;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PDU  = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } crc_state_e;

  // One Galois step of x^24+x^10+x^9+x^6+x^4+x^3+x+1; the tap mask carries
  // the feedback into bits 0,1,3,4,6,9,10.
  function automatic logic [23:0] crc24_step(input logic [23:0] lfsr_cur,
                                             input logic        din);
    logic nb;
    nb = lfsr_cur[23] ^ din;
    return {lfsr_cur[22:0], 1'b0} ^ (nb ? CRC_POLY_TAPS : 24'h000000);
  endfunction

  // The init word is delivered byte 0 first; byte 0 lands in the top of the LFSR.
  function automatic logic [23:0] crc24_init_swap(input logic [23:0] init);
    return {init[7:0], init[15:8], init[23:16]};
  endfunction

endpackage

// File: rtl/ble_crc24_rx_check.sv
// RX-side BLE CRC24 checker: runs the PDU bits through the LFSR, then compares
// the 24 received CRC bits against the register and reports pass/fail.
//
// state   | meaning
// IDLE    | waiting for start, data ignored
// PDU     | stepping LFSR over header+payload bits
// CRC     | comparing received CRC bits against lfsr[23]
// DONE    | one-cycle verdict, result_valid high
module ble_crc24_rx_check
  import ble_crc_pkg::*;
#(
  parameter int CRC_STATE_BIT_WIDTH = 24,
  parameter int LEN_WIDTH           = 9,
  parameter int BIT_CNT_WIDTH       = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  input  logic [LEN_WIDTH-1:0]           pdu_len_byte,
  input  logic                           start,
  input  logic                           data_in,
  input  logic                           data_in_valid,
  output logic                           busy,
  output logic                           result_valid,
  output logic                           crc_ok,
  output logic                           crc_err,
  output logic [CRC_STATE_BIT_WIDTH-1:0] lfsr,
  output logic [CRC_STATE_BIT_WIDTH-1:0] crc_rx
);

  crc_state_e               state;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic                     mismatch;
  logic                     mismatch_next;
  logic [BIT_CNT_WIDTH-1:0] len_bits;
  logic                     last_bit;

  assign len_bits      = BIT_CNT_WIDTH'({pdu_len_byte, 3'b000});
  assign last_bit      = (bit_cnt == BIT_CNT_WIDTH'(1));
  assign mismatch_next = mismatch | (data_in ^ lfsr[CRC_STATE_BIT_WIDTH-1]);

  assign busy         = (state == ST_PDU) || (state == ST_CRC);
  assign result_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lfsr     <= '0;
      crc_rx   <= '0;
      bit_cnt  <= '0;
      mismatch <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
    end else if (start) begin
      // start wins in every state; a coincident data bit is dropped
      lfsr     <= crc24_init_swap(crc_state_init_bit);
      mismatch <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      if (pdu_len_byte == '0) begin
        state   <= ST_CRC;
        bit_cnt <= BIT_CNT_WIDTH'(CRC_LEN);
      end else begin
        state   <= ST_PDU;
        bit_cnt <= len_bits;
      end
    end else begin
      case (state)
        ST_IDLE: ;
        ST_PDU: begin
          if (data_in_valid) begin
            lfsr <= crc24_step(lfsr, data_in);
            if (last_bit) begin
              state   <= ST_CRC;
              bit_cnt <= BIT_CNT_WIDTH'(CRC_LEN);
            end else begin
              bit_cnt <= bit_cnt - BIT_CNT_WIDTH'(1);
            end
          end
        end
        ST_CRC: begin
          if (data_in_valid) begin
            // a matching bit cancels lfsr[23], so a clean frame drains to zero
            lfsr     <= crc24_step(lfsr, data_in);
            crc_rx   <= {crc_rx[CRC_STATE_BIT_WIDTH-2:0], data_in};
            mismatch <= mismatch_next;
            if (last_bit) begin
              state   <= ST_DONE;
              bit_cnt <= '0;
              crc_ok  <= ~mismatch_next;
              crc_err <= mismatch_next;
            end else begin
              bit_cnt <= bit_cnt - BIT_CNT_WIDTH'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ble_crc24_rx_check.sv
// Directed bench for ble_crc24_rx_check; verdicts are checked against a
// scoreboard queue filled as each frame is driven.
module tb_ble_crc24_rx_check;

  localparam logic [23:0] TB_POLY = 24'h00065B;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] crc_state_init_bit;
  logic [8:0]  pdu_len_byte;
  logic        start;
  logic        data_in;
  logic        data_in_valid;
  logic        busy;
  logic        result_valid;
  logic        crc_ok;
  logic        crc_err;
  logic [23:0] lfsr;
  logic [23:0] crc_rx;

  typedef struct {
    logic        ok;
    logic        err;
    logic [23:0] lfsr;
    logic [23:0] crc_rx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rv_count = 0;
  int   busy_cycles = 0;

  ble_crc24_rx_check dut (
    .clk(clk), .rst(rst), .crc_state_init_bit(crc_state_init_bit),
    .pdu_len_byte(pdu_len_byte), .start(start), .data_in(data_in),
    .data_in_valid(data_in_valid), .busy(busy), .result_valid(result_valid),
    .crc_ok(crc_ok), .crc_err(crc_err), .lfsr(lfsr), .crc_rx(crc_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (result_valid === 1'b1) begin
      exp_t e;
      rv_count++;
      if (sb.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("verdict_ok", {31'd0, crc_ok}, {31'd0, e.ok});
        check("verdict_err", {31'd0, crc_err}, {31'd0, e.err});
        check("verdict_lfsr", {8'd0, lfsr}, {8'd0, e.lfsr});
        check("verdict_crc_rx", {8'd0, crc_rx}, {8'd0, e.crc_rx});
        check("verdict_busy_low", {31'd0, busy}, 32'd0);
      end
    end
  end

  function automatic logic [23:0] model_step(input logic [23:0] l, input logic d);
    logic [23:0] n;
    n = {l[22:0], 1'b0};
    if (l[23] ^ d) n = n ^ TB_POLY;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] init, input logic [8:0] len);
    crc_state_init_bit = init;
    pdu_len_byte = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin
    logic [23:0] m;
    logic [23:0] flipped;
    int rv_before;

    rst = 1'b1; start = 1'b0; data_in = 1'b0; data_in_valid = 1'b0;
    crc_state_init_bit = '0; pdu_len_byte = '0;
    tick(); tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rv", {31'd0, result_valid}, 32'd0);
    check("reset_ok_err", {30'd0, crc_ok, crc_err}, 32'd0);
    check("reset_lfsr", {8'd0, lfsr}, 32'd0);
    check("reset_crc_rx", {8'd0, crc_rx}, 32'd0);
    rst = 1'b0;
    tick();

    // Init byte order: byte 0 (init[7:0]) must land in lfsr[23:16]
    do_start(24'h123456, 9'd0);
    check("init_swap", {8'd0, lfsr}, 32'h00563412);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Advertising init, empty PDU, correct CRC
    sb.push_back('{ok: 1'b1, err: 1'b0, lfsr: 24'h000000, crc_rx: 24'h555555});
    do_start(24'h555555, 9'd0);
    for (int i = 23; i >= 1; i--) send_bit(i[0] ? 1'b0 : 1'b1);
    check("latency_rv_not_early", {31'd0, result_valid}, 32'd0);
    send_bit(1'b1);
    check("latency_rv_on_24th", {31'd0, result_valid}, 32'd1);
    tick(); tick();
    check("ok_held", {30'd0, crc_ok, crc_err}, 32'd2);
    check("rv_one_cycle", {31'd0, result_valid}, 32'd0);

    // Same frame with the 5th CRC bit flipped
    flipped = 24'h555555 ^ 24'h080000;
    m = 24'h555555;
    for (int i = 23; i >= 0; i--) m = model_step(m, flipped[i]);
    sb.push_back('{ok: 1'b0, err: 1'b1, lfsr: m, crc_rx: 24'h5D5555});
    do_start(24'h555555, 9'd0);
    check("start_clears_ok", {30'd0, crc_ok, crc_err}, 32'd0);
    send_word(flipped);
    tick();

    // One PDU byte 0x01 (bit 1 first) from zero init
    do_start(24'h000000, 9'd1);
    send_bit(1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    check("lfsr_after_pdu", {8'd0, lfsr}, 32'h00032D80);
    sb.push_back('{ok: 1'b1, err: 1'b0, lfsr: 24'h000000, crc_rx: 24'h032D80});
    send_word(24'h032D80);
    tick();

    // Two zero bytes with valid gaps on every other cycle
    rv_before = rv_count;
    busy_cycles = 0;
    sb.push_back('{ok: 1'b1, err: 1'b0, lfsr: 24'h000000, crc_rx: 24'h000000});
    do_start(24'h000000, 9'd2);
    for (int i = 0; i < 40; i++) begin
      data_in_valid = 1'b0;
      tick();
      send_bit(1'b0);
    end
    tick(); tick();
    check("gap_busy_cycles", busy_cycles, 32'd80);
    check("gap_single_rv", rv_count - rv_before, 32'd1);

    // Abort mid-PDU; the bit coinciding with the restart must be dropped
    rv_before = rv_count;
    do_start(24'h000000, 9'd2);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    data_in = 1'b1;
    data_in_valid = 1'b1;
    do_start(24'h555555, 9'd0);
    data_in_valid = 1'b0;
    check("abort_reload_lfsr", {8'd0, lfsr}, 32'h00555555);
    sb.push_back('{ok: 1'b1, err: 1'b0, lfsr: 24'h000000, crc_rx: 24'h555555});
    send_word(24'h555555);
    tick(); tick();
    check("abort_single_rv", rv_count - rv_before, 32'd1);

    // Reset during the CRC phase
    rv_before = rv_count;
    do_start(24'h555555, 9'd0);
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_ok", {31'd0, crc_ok}, 32'd0);
    check("rst_lfsr", {8'd0, lfsr}, 32'd0);
    for (int i = 0; i < 30; i++) send_bit(1'b1);
    tick();
    check("idle_ignores_lfsr", {8'd0, lfsr}, 32'd0);
    check("idle_ignores_crc_rx", {8'd0, crc_rx}, 32'd0);
    check("idle_no_rv", rv_count - rv_before, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    check("total_verdicts", rv_count, 32'd5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
